// File: rtl/adc_seg_pkg.sv
// adc_seg_pkg: shared definitions for the ADC seven-segment display slice.
//   - seven-segment patterns (active-low, bit order {g,f,e,d,c,b,a})
//   - controller state encoding
//   - width helpers: ch_w (channel select width), mv_w (millivolt width), pow10
package adc_seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScale,
    StConvert,
    StLatch
  } state_e;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  // Channel select width; at least one bit even for a single channel.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Bits needed to hold any millivolt value 0..full_scale.
  function automatic int unsigned mv_w(input int unsigned full_scale);
    return $clog2(full_scale + 1);
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // BCD digit to active-low segments; non-decimal codes show blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SegBlank;
    endcase
  endfunction

endpackage

// File: rtl/adc_seg_display_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble binary to BCD converter.
//   clk, reset_n : clock, asynchronous active-low reset
//   start_i      : load bin_i and begin conversion (one-cycle pulse)
//   bin_i        : binary value, BIN_W bits
//   done_o       : high during the final shift step; bcd_o is valid the cycle after
//   bcd_o        : NUM_DIGITS packed BCD nibbles, digit 0 in bits [3:0]
// One add-3/shift step per cycle, BIN_W steps per conversion.
module bin2bcd_seq #(
  parameter int unsigned BIN_W      = 13,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic                   run_q, run_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] sh;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    sh = {adj, bin_q} << 1;

    run_d = run_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = CNT_W'(BIN_W - 1);
      bin_d = bin_i;
      bcd_d = '0;
    end else if (run_q) begin
      bcd_d = sh[BCD_W+BIN_W-1:BIN_W];
      bin_d = sh[BIN_W-1:0];
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/adc_seg_display.sv
// adc_seg_display: per-channel ADC sample store, millivolt scaler and
// seven-segment driver with fixed decimal point.
//   clk, reset_n          : clock, asynchronous active-low reset
//   sample_valid/ch/code  : incoming ADC sample for one channel
//   ch_sel                : channel shown on the display
//   hold                  : freeze display; no new conversion starts
//   seg                   : active-low {g..a} per digit, digit 0 in seg[6:0]
//   dp                    : active-low decimal points
//   busy                  : conversion in progress
//   update                : one-cycle pulse when seg/dp are rewritten
module adc_seg_display
  import adc_seg_pkg::*;
#(
  parameter int unsigned ADC_BITS      = 12,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned FULL_SCALE_MV = 5000,
  parameter int unsigned DP_POS        = 3,
  parameter bit          LZ_BLANK      = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_valid,
  input  logic [ch_w(NUM_CH)-1:0]   sample_ch,
  input  logic [ADC_BITS-1:0]       sample_code,
  input  logic [ch_w(NUM_CH)-1:0]   ch_sel,
  input  logic                      hold,
  output logic [7*NUM_DIGITS-1:0]   seg,
  output logic [NUM_DIGITS-1:0]     dp,
  output logic                      busy,
  output logic                      update
);

  localparam int unsigned CH_W     = ch_w(NUM_CH);
  localparam int unsigned MV_W     = mv_w(FULL_SCALE_MV);
  localparam int unsigned PROD_W   = ADC_BITS + MV_W;
  localparam int unsigned BCD_W    = 4 * NUM_DIGITS;
  localparam int unsigned MV_LIMIT = pow10(NUM_DIGITS);

  logic [ADC_BITS-1:0]     code_q [NUM_CH];
  logic [ADC_BITS-1:0]     code_d [NUM_CH];
  logic [CH_W-1:0]         ch_sel_prev_q;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    pending_q, pending_d;
  state_e                  state_q, state_d;
  logic                    ovf_q, ovf_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    update_q, update_d;

  logic                    trig;
  logic [PROD_W-1:0]       prod;
  logic [MV_W-1:0]         mv;
  logic [31:0]             mv_ext;
  logic                    bcd_start;
  logic                    bcd_done;
  logic [BCD_W-1:0]        bcd;
  logic [7*NUM_DIGITS-1:0] enc_seg;
  logic [NUM_DIGITS-1:0]   enc_dp;

  // Channel store; out-of-range channels are dropped.
  always_comb begin
    code_d = code_q;
    if (sample_valid && (32'(sample_ch) < NUM_CH)) begin
      code_d[sample_ch] = sample_code;
    end
  end

  // A fresh sample for the shown channel and a channel switch in the same
  // cycle collapse into one trigger.
  assign trig = (sample_valid && (sample_ch == ch_sel)) || (ch_sel != ch_sel_prev_q);

  // Truncating scale: mv = code * FULL_SCALE_MV / 2^ADC_BITS.
  assign prod   = PROD_W'(code_q[ch_q]) * PROD_W'(FULL_SCALE_MV);
  assign mv     = MV_W'(prod >> ADC_BITS);
  assign mv_ext = 32'(mv);

  bin2bcd_seq #(
    .BIN_W      (MV_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (bcd_start),
    .bin_i   (mv),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Segment encoder with leading-zero blanking left of the decimal point.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    enc_seg = '0;
    enc_dp  = '1;
    lead    = LZ_BLANK;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (lead && (i > int'(DP_POS)) && (nib == 4'd0)) begin
        enc_seg[7*i +: 7] = SegBlank;
      end else begin
        enc_seg[7*i +: 7] = seg_of(nib);
      end
      if (nib != 4'd0) begin
        lead = 1'b0;
      end
    end
    if (ovf_q) begin
      enc_seg = {NUM_DIGITS{SegDash}};
    end else begin
      enc_dp[DP_POS] = 1'b0;
    end
  end

  // Controller: pending coalesces any number of triggers into one re-run.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | trig;
    ch_d      = ch_q;
    ovf_d     = ovf_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    update_d  = 1'b0;
    bcd_start = 1'b0;
    case (state_q)
      StIdle: begin
        if ((pending_q || trig) && !hold) begin
          state_d   = StScale;
          pending_d = 1'b0;
          ch_d      = ch_sel;
        end
      end
      StScale: begin
        ovf_d     = (mv_ext >= MV_LIMIT);
        bcd_start = 1'b1;
        state_d   = StConvert;
      end
      StConvert: begin
        if (bcd_done) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        seg_d    = enc_seg;
        dp_d     = enc_dp;
        update_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q        <= '{default: '0};
      ch_sel_prev_q <= '0;
      ch_q          <= '0;
      pending_q     <= 1'b0;
      state_q       <= StIdle;
      ovf_q         <= 1'b0;
      seg_q         <= '1;
      dp_q          <= '1;
      update_q      <= 1'b0;
    end else begin
      code_q        <= code_d;
      ch_sel_prev_q <= ch_sel;
      ch_q          <= ch_d;
      pending_q     <= pending_d;
      state_q       <= state_d;
      ovf_q         <= ovf_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      update_q      <= update_d;
    end
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign update = update_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_adc_seg_display.sv
// Scoreboard bench: stimulus pushes hand-computed displays into a queue,
// a monitor pops and compares on every update pulse.
// dut1: default parameters. dut2: FULL_SCALE_MV=12000, DP_POS=1 (overflow and
// leading-zero blanking cases).
module tb_adc_seg_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  typedef struct packed {
    logic [27:0] seg;
    logic [3:0]  dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid, hold;
  logic [1:0]  sample_ch, ch_sel;
  logic [11:0] sample_code;
  logic [27:0] seg;
  logic [3:0]  dp;
  logic        busy, update;

  logic        v2, hold2;
  logic [1:0]  ch2, sel2;
  logic [11:0] code2;
  logic [27:0] seg2;
  logic [3:0]  dp2;
  logic        busy2, update2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_issue = 0;
  int upd_cnt1 = 0;
  int upd_cnt2 = 0;
  int upd_cyc1 = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  adc_seg_display dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_code  (sample_code),
    .ch_sel       (ch_sel),
    .hold         (hold),
    .seg          (seg),
    .dp           (dp),
    .busy         (busy),
    .update       (update)
  );

  adc_seg_display #(
    .FULL_SCALE_MV (12000),
    .DP_POS        (1)
  ) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (v2),
    .sample_ch    (ch2),
    .sample_code  (code2),
    .ch_sel       (sel2),
    .hold         (hold2),
    .seg          (seg2),
    .dp           (dp2),
    .busy         (busy2),
    .update       (update2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [27:0] s, input logic [3:0] d);
    exp_t r;
    r.seg = s;
    r.dp  = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && update) begin
      upd_cnt1++;
      upd_cyc1 = cyc;
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_unexpected_update: got seg=%h dp=%b expected no update", seg, dp);
      end else begin
        e1 = q1.pop_front();
        check("dut1_seg", 64'(seg), 64'(e1.seg));
        check("dut1_dp", 64'(dp), 64'(e1.dp));
      end
    end
    if (reset_n && update2) begin
      upd_cnt2++;
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut2_unexpected_update: got seg=%h dp=%b expected no update", seg2, dp2);
      end else begin
        e2 = q2.pop_front();
        check("dut2_seg", 64'(seg2), 64'(e2.seg));
        check("dut2_dp", 64'(dp2), 64'(e2.dp));
      end
    end
  end

  task automatic send1(input logic [1:0] ch, input logic [11:0] code);
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_code  = code;
    t_issue      = cyc;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send2(input logic [11:0] code);
    @(posedge clk);
    #1;
    v2    = 1'b1;
    code2 = code;
    @(posedge clk);
    #1;
    v2 = 1'b0;
  endtask

  task automatic set_sel(input logic [1:0] s);
    @(posedge clk);
    #1;
    ch_sel  = s;
    t_issue = cyc;
  endtask

  task automatic wait_cnt1(input int target, input int budget);
    int k;
    k = 0;
    while (upd_cnt1 < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("dut1_update_seen", 64'(upd_cnt1 >= target), 64'd1);
  endtask

  task automatic vec2(input logic [11:0] code, input logic [27:0] s, input logic [3:0] d);
    int target;
    int k;
    target = upd_cnt2 + 1;
    q2.push_back(mk(s, d));
    send2(code);
    k = 0;
    while (upd_cnt2 < target && k < 40) begin
      @(posedge clk);
      k++;
    end
    check("dut2_update_seen", 64'(upd_cnt2 >= target), 64'd1);
  endtask

  initial begin
    sample_valid = 1'b0;
    sample_ch    = '0;
    sample_code  = '0;
    ch_sel       = '0;
    hold         = 1'b0;
    v2           = 1'b0;
    ch2          = '0;
    code2        = '0;
    sel2         = '0;
    hold2        = 1'b0;
    reset_n      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg", 64'(seg), 64'({SB, SB, SB, SB}));
    check("rst_dp", 64'(dp), 64'(4'b1111));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_update", 64'(update), 64'd0);
    check("rst_seg2", 64'(seg2), 64'({SB, SB, SB, SB}));
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_blank", 64'(seg), 64'({SB, SB, SB, SB}));
    check("post_rst_busy", 64'(busy), 64'd0);

    // 4095 -> 4998 mV, "4.998"
    q1.push_back(mk({S4, S9, S9, S8}, 4'b0111));
    send1(2'd0, 12'd4095);
    wait_cnt1(1, 40);
    check("latency_sample", 64'(upd_cyc1 - t_issue), 64'd16);
    @(negedge clk);
    check("update_one_cycle", 64'(update), 64'd0);

    // Sample for an unselected channel must not trigger.
    send1(2'd1, 12'd2048);
    repeat (20) @(posedge clk);
    check("unselected_no_update", 64'(upd_cnt1), 64'd1);

    // Switching to ch1 shows "2.500".
    q1.push_back(mk({S2, S5, S0, S0}, 4'b0111));
    set_sel(2'd1);
    wait_cnt1(2, 40);
    check("latency_sel_change", 64'(upd_cyc1 - t_issue), 64'd16);

    // Code 0 shows "0.000" with nothing blanked.
    q1.push_back(mk({S0, S0, S0, S0}, 4'b0111));
    send1(2'd1, 12'd0);
    wait_cnt1(3, 40);

    // Three samples during one conversion: first value, then the last one.
    q1.push_back(mk({S4, S9, S9, S8}, 4'b0111));
    q1.push_back(mk({S2, S5, S0, S0}, 4'b0111));
    send1(2'd1, 12'd4095);
    send1(2'd1, 12'd0);
    send1(2'd1, 12'd2048);
    wait_cnt1(5, 80);
    repeat (30) @(posedge clk);
    check("coalesce_count", 64'(upd_cnt1), 64'd5);

    // Hold freezes the display; release starts the pending conversion.
    @(posedge clk);
    #1 hold = 1'b1;
    send1(2'd1, 12'd4095);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("hold_no_update", 64'(upd_cnt1), 64'd5);
    check("hold_not_busy", 64'(busy), 64'd0);
    check("hold_seg_frozen", 64'(seg), 64'({S2, S5, S0, S0}));
    q1.push_back(mk({S4, S9, S9, S8}, 4'b0111));
    @(posedge clk);
    #1;
    hold    = 1'b0;
    t_issue = cyc;
    wait_cnt1(6, 40);
    check("latency_hold_release", 64'(upd_cyc1 - t_issue), 64'd16);

    // dut2: 12000 mV full scale, decimal point on digit 1.
    vec2(12'd4095, {SD, SD, SD, SD}, 4'b1111);
    vec2(12'd3413, {S9, S9, S9, S9}, 4'b1101);
    vec2(12'd3414, {SD, SD, SD, SD}, 4'b1111);
    vec2(12'd100, {SB, S2, S9, S2}, 4'b1101);
    vec2(12'd10, {SB, SB, S2, S9}, 4'b1101);
    vec2(12'd0, {SB, SB, S0, S0}, 4'b1101);

    // Reset during CONVERT step 5 aborts with no update.
    send1(2'd1, 12'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_converting", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    ch_sel  = 2'd0;
    #1;
    check("abort_seg_blank", 64'(seg), 64'({SB, SB, SB, SB}));
    check("abort_dp", 64'(dp), 64'(4'b1111));
    check("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort_no_update", 64'(upd_cnt1), 64'd6);
    check("abort_stays_blank", 64'(seg), 64'({SB, SB, SB, SB}));

    // Channel store was cleared by reset: ch1 now reads "0.000".
    q1.push_back(mk({S0, S0, S0, S0}, 4'b0111));
    set_sel(2'd1);
    wait_cnt1(7, 40);

    repeat (5) @(posedge clk);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
